// File: rtl/mem_sort_controller.sv
// In-place ascending bubble sort of N 32-bit words over a single data-memory port.
// Early-terminating passes; start/busy/done handshake plus a running swap count.
module mem_sort_controller #(
   parameter int          N          = 10,
   parameter logic [31:0] BASE_ADDR  = 32'h0,
   parameter bit          SIGNED_CMP = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] readData,
   output logic        MemRead,
   output logic        MemWrite,
   output logic [31:0] address,
   output logic [31:0] writeData,
   output logic        busy,
   output logic        done,
   output logic [15:0] swap_count
);

   typedef enum logic [2:0] {IDLE, RD_A, RD_B, CMP, WR_A, WR_B, DONE} state_t;

   localparam int            IW         = 9;
   localparam bit            MULTI      = (N >= 2);
   localparam logic [IW-1:0] LIMIT_INIT = IW'((N >= 2) ? N - 1 : 0);

   state_t        state, state_n;
   logic [IW-1:0] j, j_inc, limit, idx;
   logic          swapped, swapped_eff;
   logic [31:0]   reg_a, reg_b, wdata;
   logic [15:0]   swap_cnt_q;
   logic          a_gt_b;
   logic          accept, begin_sort, adv, adv_j, new_pass;
   logic          mem_rd, mem_wr, in_busy, in_done;

   assign j_inc = j + IW'(1);

   always_comb begin
      if (SIGNED_CMP) a_gt_b = $signed(reg_a) > $signed(reg_b);
      else            a_gt_b = reg_a > reg_b;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of process evaluation order.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   // NOTE: every signal driven here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_n     = state;
      accept      = 1'b0;
      begin_sort  = 1'b0;
      adv         = 1'b0;
      adv_j       = 1'b0;
      new_pass    = 1'b0;
      mem_rd      = 1'b0;
      mem_wr      = 1'b0;
      in_busy     = 1'b0;
      in_done     = 1'b0;
      idx         = j;
      wdata       = '0;
      swapped_eff = swapped | (state == WR_B);

      unique case (state)
         IDLE: begin
            if (start) begin
               accept = 1'b1;
               if (MULTI) begin
                  begin_sort = 1'b1;
                  state_n    = RD_A;
               end else begin
                  state_n = DONE;
               end
            end
         end
         RD_A: begin
            mem_rd  = 1'b1;
            in_busy = 1'b1;
            state_n = RD_B;
         end
         RD_B: begin
            mem_rd  = 1'b1;
            in_busy = 1'b1;
            idx     = j_inc;
            state_n = CMP;
         end
         CMP: begin
            in_busy = 1'b1;
            if (a_gt_b) state_n = WR_A;
            else        adv     = 1'b1;
         end
         WR_A: begin
            mem_wr  = 1'b1;
            in_busy = 1'b1;
            wdata   = reg_b;
            state_n = WR_B;
         end
         WR_B: begin
            mem_wr  = 1'b1;
            in_busy = 1'b1;
            idx     = j_inc;
            wdata   = reg_a;
            adv     = 1'b1;
         end
         DONE: begin
            in_done = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase

      // A pass with no swap (counting one made this cycle) means the block is sorted.
      if (adv) begin
         if (j_inc < limit) begin
            adv_j   = 1'b1;
            state_n = RD_A;
         end else if (!swapped_eff || limit == IW'(1)) begin
            state_n = DONE;
         end else begin
            new_pass = 1'b1;
            state_n  = RD_A;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         j          <= '0;
         limit      <= '0;
         swapped    <= 1'b0;
         reg_a      <= '0;
         reg_b      <= '0;
         swap_cnt_q <= '0;
      end else begin
         if (accept) swap_cnt_q <= '0;
         if (begin_sort) begin
            j       <= '0;
            limit   <= LIMIT_INIT;
            swapped <= 1'b0;
         end
         if (state == RD_A) reg_a <= readData;
         if (state == RD_B) reg_b <= readData;
         if (state == WR_B) begin
            swapped    <= 1'b1;
            swap_cnt_q <= swap_cnt_q + 16'd1;
         end
         if (adv_j) j <= j_inc;
         if (new_pass) begin
            limit   <= limit - IW'(1);
            j       <= '0;
            swapped <= 1'b0;
         end
      end
   end

   // Reset forces every output low in the same cycle, so a write caught mid-swap never lands.
   assign MemRead    = mem_rd & ~reset;
   assign MemWrite   = mem_wr & ~reset;
   assign address    = ((mem_rd | mem_wr) & ~reset) ? BASE_ADDR + {21'b0, idx, 2'b00} : '0;
   assign writeData  = (mem_wr & ~reset) ? wdata : '0;
   assign busy       = in_busy & ~reset;
   assign done       = in_done & ~reset;
   assign swap_count = reset ? '0 : swap_cnt_q;

endmodule

// File: tb/tb_mem_sort_controller.sv
// Scoreboard bench for mem_sort_controller: five instances (N=10, 4, 2 unsigned, 2 signed, 1)
// sharing clock/reset, each with its own combinational-read word memory.
module tb_mem_sort_controller;

   typedef logic [0:9][31:0] blk_t;
   typedef struct packed {
      logic [2:0]  inst;
      logic [15:0] swaps;
      logic [31:0] lat;
      blk_t        words;
   } exp_t;

   localparam int NI = 5;

   logic           clk     = 1'b0;
   logic           reset   = 1'b1;
   logic [NI-1:0]  start_v = '0;
   logic [31:0]    rd  [NI];
   wire  [NI-1:0]  mr, mw, bsy, dn;
   wire  [31:0]    adr [NI];
   wire  [31:0]    wd  [NI];
   wire  [15:0]    sc  [NI];

   blk_t           mem [NI];
   logic [31:0]    off [NI];
   logic [3:0]     idx [NI];
   logic [NI-1:0]  inr;
   logic           load_en = 1'b0;
   int             load_g  = 0;
   blk_t           load_w  = '0;

   exp_t           sb [$];
   int             pass_cnt = 0;
   int             chk_cnt  = 0;
   int             cyc      = 0;
   int             start_cyc = 0;
   int             overlap_cnt = 0;
   int             oor_cnt  = 0;
   int             strobe_cnt [NI];
   int             wr_cnt     [NI];
   int             done_cnt   [NI];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int n_of(input int g);
      case (g)
         0:       return 10;
         1:       return 4;
         2, 3:    return 2;
         default: return 1;
      endcase
   endfunction

   function automatic logic [31:0] base_of(input int g);
      return (g == 1) ? 32'h100 : 32'h0;
   endfunction

   function automatic blk_t seq(input int first, input int step);
      blk_t b;
      for (int k = 0; k < 10; k++) b[k] = 32'(first + step * k);
      return b;
   endfunction

   for (genvar g = 0; g < NI; g++) begin : g_dut
      mem_sort_controller #(
         .N          (g == 0 ? 10 : g == 1 ? 4 : g < 4 ? 2 : 1),
         .BASE_ADDR  (g == 1 ? 32'h100 : 32'h0),
         .SIGNED_CMP (g == 3)
      ) u_dut (
         .clk        (clk),
         .reset      (reset),
         .start      (start_v[g]),
         .readData   (rd[g]),
         .MemRead    (mr[g]),
         .MemWrite   (mw[g]),
         .address    (adr[g]),
         .writeData  (wd[g]),
         .busy       (bsy[g]),
         .done       (dn[g]),
         .swap_count (sc[g])
      );
   end

   always_comb begin
      for (int g = 0; g < NI; g++) begin
         off[g] = adr[g] - base_of(g);
         idx[g] = off[g][5:2];
         inr[g] = (off[g][1:0] == 2'b00) && ((off[g] >> 2) < 32'(n_of(g)));
         rd[g]  = inr[g] ? mem[g][idx[g]] : 32'hDEAD_BEEF;
      end
   end

   always @(posedge clk) begin
      if (load_en) mem[load_g] <= load_w;
      for (int g = 0; g < NI; g++)
         if (mw[g] && inr[g]) mem[g][idx[g]] <= wd[g];
   end

   task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Protocol monitor: strobe overlap, address range and event counts.
   initial begin
      for (int g = 0; g < NI; g++) begin
         strobe_cnt[g] = 0;
         wr_cnt[g]     = 0;
         done_cnt[g]   = 0;
      end
      forever begin
         @(negedge clk);
         for (int g = 0; g < NI; g++) begin
            if (mr[g] && mw[g]) overlap_cnt++;
            if ((mr[g] || mw[g]) && !inr[g]) oor_cnt++;
            if (mr[g] || mw[g]) strobe_cnt[g]++;
            if (mw[g]) wr_cnt[g]++;
            if (dn[g]) done_cnt[g]++;
         end
      end
   end

   // Scoreboard monitor: every done pulse pops one expected result.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         for (int g = 0; g < NI; g++) begin
            if (dn[g] === 1'b1) begin
               if (sb.size() == 0) begin
                  check($sformatf("unexpected_done[%0d]", g), dn[g], 0);
               end else begin
                  e = sb.pop_front();
                  check($sformatf("done_inst[%0d]", g), g, e.inst);
                  check($sformatf("swap_count[%0d]", g), sc[g], e.swaps);
                  check($sformatf("sorted_mem[%0d]", g), mem[g], e.words);
                  check($sformatf("busy_at_done[%0d]", g), bsy[g], 0);
                  if (e.lat != 0)
                     check($sformatf("done_latency[%0d]", g), cyc - start_cyc + 1, e.lat);
               end
            end
         end
      end
   end

   task automatic load(input int g, input blk_t w);
      @(negedge clk);
      load_g  = g;
      load_w  = w;
      load_en = 1'b1;
      @(negedge clk);
      load_en = 1'b0;
   endtask

   task automatic pulse_start(input int g);
      @(negedge clk);
      start_cyc  = cyc + 1;
      start_v[g] = 1'b1;
      @(negedge clk);
      start_v[g] = 1'b0;
   endtask

   task automatic issue(input int g, input logic [15:0] swaps, input blk_t words, input int lat);
      exp_t e;
      e.inst  = 3'(g);
      e.swaps = swaps;
      e.lat   = 32'(lat);
      e.words = words;
      sb.push_back(e);
      pulse_start(g);
   endtask

   task automatic wait_done(input int g);
      int n = 0;
      while (dn[g] !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("done_seen[%0d]", g), dn[g], 1);
      repeat (2) @(negedge clk);
   endtask

   // Runs one sort on instance g and checks the single-pulse and quiescent-after behaviour.
   task automatic run(input int g, input logic [15:0] swaps, input blk_t words, input int lat);
      int dc0 = done_cnt[g];
      check($sformatf("busy_before[%0d]", g), bsy[g], 0);
      issue(g, swaps, words, lat);
      wait_done(g);
      check($sformatf("done_pulses[%0d]", g), done_cnt[g] - dc0, 1);
      check($sformatf("busy_after[%0d]", g), bsy[g], 0);
      check($sformatf("swap_count_held[%0d]", g), sc[g], swaps);
   endtask

   localparam blk_t MIXED  = {32'd7, 32'd8, 32'd1, 32'd9, 32'd2, 32'd6, 32'd3, 32'd10, 32'd4, 32'd5};
   localparam blk_t DUPS   = {32'd5, 32'd5, 32'd3, 32'd3, 192'd0};
   localparam blk_t DUPS_S = {32'd3, 32'd3, 32'd5, 32'd5, 192'd0};
   localparam blk_t SG_IN  = {32'd1, 32'hFFFF_FFFF, 256'd0};
   localparam blk_t SG_SW  = {32'hFFFF_FFFF, 32'd1, 256'd0};
   localparam blk_t ONE    = {32'd42, 288'd0};
   localparam blk_t PART   = {32'd9, 32'd10, 32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};

   initial begin
      int n;
      int w0, s0;

      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (5) begin
         @(negedge clk);
         for (int g = 0; g < NI; g++)
            check($sformatf("idle_outputs[%0d]", g),
                  {mr[g], mw[g], adr[g], wd[g], bsy[g], dn[g], sc[g]}, 0);
      end

      load(1, DUPS);
      load(2, SG_IN);
      load(3, SG_IN);
      load(4, ONE);

      load(0, MIXED);
      run(0, 16'd22, seq(1, 1), 0);

      load(0, MIXED);
      issue(0, 16'd22, seq(1, 1), 0);
      repeat (20) @(negedge clk);
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      s0 = done_cnt[0];
      wait_done(0);
      check("restart_ignored_pulses", done_cnt[0] - s0, 1);

      load(0, seq(1, 1));
      w0 = wr_cnt[0];
      run(0, 16'd0, seq(1, 1), 28);
      check("sorted_no_writes", wr_cnt[0] - w0, 0);

      load(0, seq(10, -1));
      run(0, 16'd45, seq(1, 1), 0);

      run(1, 16'd4, DUPS_S, 0);
      run(2, 16'd0, SG_IN, 0);
      run(3, 16'd1, SG_SW, 0);

      s0 = strobe_cnt[4];
      run(4, 16'd0, ONE, 1);
      check("n1_no_strobes", strobe_cnt[4] - s0, 0);

      load(0, seq(10, -1));
      pulse_start(0);
      n = 0;
      while (!(mw[0] && adr[0] == 32'd4 && wd[0] == 32'd8) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("reached_second_wr_a", {mw[0], adr[0], wd[0]}, {1'b1, 32'd4, 32'd8});
      reset = 1'b1;
      #1;
      check("reset_cycle_strobes", {mr[0], mw[0], bsy[0]}, 0);
      @(negedge clk);
      reset = 1'b0;
      check("post_reset_idle", {mr[0], mw[0], bsy[0], dn[0], sc[0]}, 0);
      check("post_reset_mem", mem[0], PART);
      repeat (2) @(negedge clk);
      check("post_reset_still_idle", {bsy[0], dn[0]}, 0);
      run(0, 16'd44, seq(1, 1), 0);

      repeat (3) @(negedge clk);
      check("no_rw_overlap", overlap_cnt, 0);
      check("address_in_range", oor_cnt, 0);
      check("scoreboard_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, %0d/%0d checks passed", pass_cnt, chk_cnt);
      $fatal(1, "global timeout");
   end

endmodule
